// File: rtl/irq_ctrl_pkg.sv
// Shared constants for the interrupt controller: register byte offsets,
// the per-channel trigger mode, and the claim-ID priority helper.
package irq_ctrl_pkg;

  localparam int unsigned OFF_MTIME_LO    = 32'h00;
  localparam int unsigned OFF_MTIME_HI    = 32'h04;
  localparam int unsigned OFF_MTIMECMP_LO = 32'h08;
  localparam int unsigned OFF_MTIMECMP_HI = 32'h0C;
  localparam int unsigned OFF_IE          = 32'h10;
  localparam int unsigned OFF_IP          = 32'h14;
  localparam int unsigned OFF_MODE        = 32'h18;
  localparam int unsigned OFF_CLAIM       = 32'h1C;

  typedef enum logic {
    MODE_LEVEL = 1'b0,
    MODE_EDGE  = 1'b1
  } irq_mode_e;

  // Lowest pending channel index plus one; zero means nothing pending.
  function automatic logic [5:0] claim_id(input logic [31:0] pend);
    logic [5:0] id;
    id = '0;
    for (int i = 31; i >= 0; i--) begin
      if (pend[i]) id = 6'(i + 1);
    end
    return id;
  endfunction

endpackage

// File: rtl/irq_sync_edge.sv
// One external request channel: two-flop synchronizer followed by a
// rising-edge detector on the synchronized level.
module irq_sync_edge (
  input  logic clk_i,
  input  logic rst_i,
  input  logic async_i,
  output logic level_o,
  output logic rise_c
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic prev_q, prev_d;

  always_comb begin
    meta_d = async_i;
    sync_d = meta_q;
    prev_d = sync_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign level_o = sync_q;
  assign rise_c  = sync_q & ~prev_q;

endmodule

// File: rtl/irq_ctrl.sv
// Machine timer plus external interrupt controller with a memory-mapped
// register port; drives the timer and external interrupt lines to the core.
module irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter int unsigned DW             = 32,
  parameter int unsigned ADDRW          = 12,
  parameter int unsigned NO_OF_EXT_IRQS = 8,
  parameter int unsigned PRESCALE       = 1
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      we_i,
  input  logic                      re_i,
  input  logic [ADDRW-1:0]          addr_i,
  input  logic [DW-1:0]             wdata_i,
  output logic [DW-1:0]             rdata_o,
  output logic                      rvalid_o,
  input  logic [NO_OF_EXT_IRQS-1:0] ext_irq_i,
  output logic                      t_intr,
  output logic                      e_intr
);

  localparam int unsigned N   = NO_OF_EXT_IRQS;
  localparam int unsigned MW  = 2 * DW;
  localparam int unsigned WW  = ADDRW - 2;
  localparam int unsigned PSW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  localparam logic [WW-1:0] W_MTIME_LO    = WW'(OFF_MTIME_LO >> 2);
  localparam logic [WW-1:0] W_MTIME_HI    = WW'(OFF_MTIME_HI >> 2);
  localparam logic [WW-1:0] W_MTIMECMP_LO = WW'(OFF_MTIMECMP_LO >> 2);
  localparam logic [WW-1:0] W_MTIMECMP_HI = WW'(OFF_MTIMECMP_HI >> 2);
  localparam logic [WW-1:0] W_IE          = WW'(OFF_IE >> 2);
  localparam logic [WW-1:0] W_IP          = WW'(OFF_IP >> 2);
  localparam logic [WW-1:0] W_MODE        = WW'(OFF_MODE >> 2);
  localparam logic [WW-1:0] W_CLAIM       = WW'(OFF_CLAIM >> 2);

  logic [MW-1:0]  mtime_q, mtime_d;
  logic [MW-1:0]  mtimecmp_q, mtimecmp_d;
  logic [PSW-1:0] presc_q, presc_d;
  logic [N-1:0]   ie_q, ie_d;
  logic [N-1:0]   mode_q, mode_d;
  logic [N-1:0]   ip_q, ip_d;
  logic           t_q, t_d;
  logic           e_q, e_d;
  logic [DW-1:0]  rdata_q, rdata_d;
  logic           rvalid_q, rvalid_d;

  logic [N-1:0]   sync_level, sync_rise;
  logic [N-1:0]   is_edge, ip_eff, pend, claim_mask, ip_clr;
  logic [WW-1:0]  word;
  logic [DW-1:0]  rd_mux;
  logic [1:0]     unused_addr_lsb;

  assign word            = addr_i[ADDRW-1:2];
  assign unused_addr_lsb = addr_i[1:0];

  for (genvar n = 0; n < N; n++) begin : g_sync
    irq_sync_edge u_sync (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .async_i (ext_irq_i[n]),
      .level_o (sync_level[n]),
      .rise_c  (sync_rise[n])
    );
  end

  // Edge channels report the latched flag, level channels the live synchronized line.
  always_comb begin
    is_edge = '0;
    for (int n = 0; n < N; n++) begin
      is_edge[n] = (irq_mode_e'(mode_q[n]) == MODE_EDGE);
    end
    ip_eff     = (ip_q & is_edge) | (sync_level & ~is_edge);
    pend       = ip_eff & ie_q;
    claim_mask = pend & (~pend + N'(1));
  end

  always_comb begin
    rd_mux = '0;
    case (word)
      W_MTIME_LO:    rd_mux = mtime_q[DW-1:0];
      W_MTIME_HI:    rd_mux = mtime_q[MW-1:DW];
      W_MTIMECMP_LO: rd_mux = mtimecmp_q[DW-1:0];
      W_MTIMECMP_HI: rd_mux = mtimecmp_q[MW-1:DW];
      W_IE:          rd_mux = DW'(ie_q);
      W_IP:          rd_mux = DW'(ip_eff);
      W_MODE:        rd_mux = DW'(mode_q);
      W_CLAIM:       rd_mux = DW'(claim_id(32'(pend)));
      default:       rd_mux = '0;
    endcase
  end

  always_comb begin
    mtime_d    = mtime_q;
    mtimecmp_d = mtimecmp_q;
    presc_d    = presc_q;
    ie_d       = ie_q;
    mode_d     = mode_q;
    ip_clr     = '0;
    t_d        = (mtime_q >= mtimecmp_q);
    e_d        = |pend;
    rvalid_d   = re_i;
    rdata_d    = re_i ? rd_mux : rdata_q;

    if (presc_q == PSW'(PRESCALE - 1)) begin
      presc_d = '0;
      mtime_d = mtime_q + MW'(1);
    end else begin
      presc_d = presc_q + PSW'(1);
    end

    // A register write to mtime overrides the tick and restarts the prescaler.
    if (we_i) begin
      case (word)
        W_MTIME_LO: begin
          mtime_d = {mtime_q[MW-1:DW], wdata_i};
          presc_d = '0;
        end
        W_MTIME_HI: begin
          mtime_d = {wdata_i, mtime_q[DW-1:0]};
          presc_d = '0;
        end
        W_MTIMECMP_LO: mtimecmp_d = {mtimecmp_q[MW-1:DW], wdata_i};
        W_MTIMECMP_HI: mtimecmp_d = {wdata_i, mtimecmp_q[DW-1:0]};
        W_IE:          ie_d       = wdata_i[N-1:0];
        W_MODE:        mode_d     = wdata_i[N-1:0];
        W_IP:          ip_clr     = wdata_i[N-1:0];
        default:       ;
      endcase
    end

    if (re_i && word == W_CLAIM) ip_clr = ip_clr | claim_mask;

    // New edges beat clears; a mode change on a channel wipes its flag.
    ip_d = (sync_rise | (ip_q & ~ip_clr)) & is_edge & ~(mode_q ^ mode_d);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mtime_q    <= '0;
      mtimecmp_q <= '1;
      presc_q    <= '0;
      ie_q       <= '0;
      mode_q     <= '0;
      ip_q       <= '0;
      t_q        <= 1'b0;
      e_q        <= 1'b0;
      rdata_q    <= '0;
      rvalid_q   <= 1'b0;
    end else begin
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      presc_q    <= presc_d;
      ie_q       <= ie_d;
      mode_q     <= mode_d;
      ip_q       <= ip_d;
      t_q        <= t_d;
      e_q        <= e_d;
      rdata_q    <= rdata_d;
      rvalid_q   <= rvalid_d;
    end
  end

  assign rdata_o  = rdata_q;
  assign rvalid_o = rvalid_q;
  assign t_intr   = t_q;
  assign e_intr   = e_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl: a register-access vector table plus
// hand-sequenced timer, interrupt and reset scenarios.
module tb_irq_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        we = 1'b0;
  logic        re = 1'b0;
  logic [11:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [7:0]  ext = '0;
  logic [31:0] rdata, rdata1;
  logic        rvalid, rvalid1;
  logic        t_intr, e_intr, t_intr1, e_intr1;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  irq_ctrl #(.DW(32), .ADDRW(12), .NO_OF_EXT_IRQS(8), .PRESCALE(4)) dut (
    .clk_i(clk), .rst_i(rst), .we_i(we), .re_i(re), .addr_i(addr),
    .wdata_i(wdata), .rdata_o(rdata), .rvalid_o(rvalid),
    .ext_irq_i(ext), .t_intr(t_intr), .e_intr(e_intr)
  );

  irq_ctrl #(.DW(32), .ADDRW(12), .NO_OF_EXT_IRQS(8), .PRESCALE(1)) dut1 (
    .clk_i(clk), .rst_i(rst), .we_i(we), .re_i(re), .addr_i(addr),
    .wdata_i(wdata), .rdata_o(rdata1), .rvalid_o(rvalid1),
    .ext_irq_i(ext), .t_intr(t_intr1), .e_intr(e_intr1)
  );

  typedef struct {
    logic        we;
    logic        re;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic        exp_rvalid;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    addr = a; wdata = d; we = 1'b1;
    tick();
    we = 1'b0;
  endtask

  task automatic rd(input logic [11:0] a, output logic [31:0] d0, output logic [31:0] d1);
    addr = a; re = 1'b1;
    tick();
    re = 1'b0;
    check("rd_rvalid", 32'(rvalid), 32'd1);
    d0 = rdata;
    d1 = rdata1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] d0, d1;

    vecs[0]  = '{1'b1, 1'b0, 12'h010, 32'hFFFF_FFFF, 1'b0, 32'h0000_0000};
    vecs[1]  = '{1'b0, 1'b1, 12'h010, 32'h0,         1'b1, 32'h0000_00FF};
    vecs[2]  = '{1'b1, 1'b0, 12'h018, 32'h0000_01FF, 1'b0, 32'h0000_00FF};
    vecs[3]  = '{1'b0, 1'b1, 12'h018, 32'h0,         1'b1, 32'h0000_00FF};
    vecs[4]  = '{1'b0, 1'b1, 12'h008, 32'h0,         1'b1, 32'hFFFF_FFFF};
    vecs[5]  = '{1'b0, 1'b1, 12'h00C, 32'h0,         1'b1, 32'hFFFF_FFFF};
    vecs[6]  = '{1'b1, 1'b0, 12'h020, 32'h0000_1234, 1'b0, 32'hFFFF_FFFF};
    vecs[7]  = '{1'b0, 1'b1, 12'h020, 32'h0,         1'b1, 32'h0000_0000};
    vecs[8]  = '{1'b0, 1'b1, 12'h014, 32'h0,         1'b1, 32'h0000_0000};
    vecs[9]  = '{1'b0, 1'b1, 12'h01C, 32'h0,         1'b1, 32'h0000_0000};
    vecs[10] = '{1'b1, 1'b1, 12'h010, 32'h0000_000F, 1'b1, 32'h0000_00FF};
    vecs[11] = '{1'b0, 1'b1, 12'h013, 32'h0,         1'b1, 32'h0000_000F};
    vecs[12] = '{1'b1, 1'b0, 12'h018, 32'h0,         1'b0, 32'h0000_000F};
    vecs[13] = '{1'b0, 1'b1, 12'h018, 32'h0,         1'b1, 32'h0000_0000};

    // Reset state
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    check("rst_t_intr", 32'(t_intr), 32'd0);
    check("rst_e_intr", 32'(e_intr), 32'd0);
    check("rst_rvalid", 32'(rvalid), 32'd0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_t_intr1", 32'(t_intr1), 32'd0);
    check("rst_e_intr1", 32'(e_intr1), 32'd0);

    // Register access table
    for (int i = 0; i < 14; i++) begin
      we = vecs[i].we; re = vecs[i].re; addr = vecs[i].addr; wdata = vecs[i].wdata;
      tick();
      check($sformatf("vec%0d_rvalid", i), 32'(rvalid), 32'(vecs[i].exp_rvalid));
      check($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp_rdata);
    end
    we = 1'b0; re = 1'b0;

    // Timer compare with prescale 4
    wr(12'h00C, 32'h0);
    wr(12'h008, 32'd10);
    wr(12'h004, 32'h0);
    wr(12'h000, 32'h0);
    repeat (40) tick();
    check("timer_before", 32'(t_intr), 32'd0);
    tick();
    check("timer_rise", 32'(t_intr), 32'd1);
    repeat (5) tick();
    check("timer_hold", 32'(t_intr), 32'd1);
    wr(12'h008, 32'hFFFF_FFFF);
    check("timer_cmp_wr_edge", 32'(t_intr), 32'd1);
    tick();
    check("timer_fall", 32'(t_intr), 32'd0);

    // Edge channel 0 pulse, claim
    wr(12'h018, 32'h01);
    wr(12'h010, 32'h01);
    ext = 8'h01;
    tick();
    ext = 8'h00;
    tick(); tick();
    check("edge0_e_early", 32'(e_intr), 32'd0);
    tick();
    check("edge0_e_set", 32'(e_intr), 32'd1);
    rd(12'h014, d0, d1);
    check("edge0_ip", d0, 32'h01);
    rd(12'h01C, d0, d1);
    check("edge0_claim", d0, 32'd1);
    check("edge0_e_claim_cycle", 32'(e_intr), 32'd1);
    tick();
    check("edge0_e_cleared", 32'(e_intr), 32'd0);
    rd(12'h014, d0, d1);
    check("edge0_ip_cleared", d0, 32'h0);

    // Claim priority across channels 5 and 2
    wr(12'h018, 32'hFF);
    wr(12'h010, 32'hFF);
    ext = 8'h24;
    tick();
    ext = 8'h00;
    repeat (3) tick();
    rd(12'h01C, d0, d1);
    check("claim_first", d0, 32'd3);
    rd(12'h01C, d0, d1);
    check("claim_second", d0, 32'd6);
    rd(12'h01C, d0, d1);
    check("claim_none", d0, 32'd0);

    // Level channel 3
    wr(12'h018, 32'h00);
    wr(12'h010, 32'h08);
    ext = 8'h08;
    repeat (4) tick();
    check("level_e_set", 32'(e_intr), 32'd1);
    wr(12'h014, 32'h08);
    rd(12'h014, d0, d1);
    check("level_ip_wr_ignored", d0, 32'h08);
    check("level_e_stays", 32'(e_intr), 32'd1);
    ext = 8'h00;
    tick(); tick();
    check("level_e_drop_lag", 32'(e_intr), 32'd1);
    tick();
    check("level_e_dropped", 32'(e_intr), 32'd0);

    // Edge on channel 1 coincident with IP clear write
    wr(12'h018, 32'h02);
    wr(12'h010, 32'h02);
    ext = 8'h02;
    tick(); tick();
    wr(12'h014, 32'h02);
    rd(12'h014, d0, d1);
    check("set_wins_ip", d0, 32'h02);
    check("set_wins_e", 32'(e_intr), 32'd1);
    wr(12'h014, 32'h02);
    rd(12'h014, d0, d1);
    check("ip_wr_clear", d0, 32'h0);
    ext = 8'h00;

    // mtime carry across halves
    wr(12'h004, 32'h0);
    wr(12'h000, 32'hFFFF_FFFF);
    tick();
    rd(12'h000, d0, d1);
    check("carry_p1_lo", d1, 32'h0);
    check("carry_p4_lo_pre", d0, 32'hFFFF_FFFF);
    rd(12'h004, d0, d1);
    check("carry_p1_hi", d1, 32'h1);
    check("carry_p4_hi_pre", d0, 32'h0);
    rd(12'h000, d0, d1);
    check("carry_p4_lo_last", d0, 32'hFFFF_FFFF);
    rd(12'h000, d0, d1);
    check("carry_p4_lo", d0, 32'h0);
    rd(12'h004, d0, d1);
    check("carry_p4_hi", d0, 32'h1);
    check("carry_t_intr", 32'(t_intr), 32'd1);

    // Reset in the middle of counting with a read in flight
    rst = 1'b1; re = 1'b1; addr = 12'h000;
    tick();
    rst = 1'b0; re = 1'b0;
    check("mid_rst_rvalid", 32'(rvalid), 32'd0);
    check("mid_rst_rdata", rdata, 32'h0);
    check("mid_rst_t_intr", 32'(t_intr), 32'd0);
    check("mid_rst_e_intr", 32'(e_intr), 32'd0);
    check("mid_rst_rvalid1", 32'(rvalid1), 32'd0);
    rd(12'h000, d0, d1);
    check("mid_rst_mtime", d0, 32'h0);
    check("mid_rst_mtime1", d1, 32'h0);
    rd(12'h00C, d0, d1);
    check("mid_rst_cmp_hi", d0, 32'hFFFF_FFFF);
    rd(12'h010, d0, d1);
    check("mid_rst_ie", d0, 32'h0);
    rd(12'h018, d0, d1);
    check("mid_rst_mode", d0, 32'h0);
    tick();
    check("mid_rst_t_after", 32'(t_intr), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/irq_ctrl.md
IRQ_CTRL -- requirements
Module: irq_ctrl

Interface
REQ-001 Parameter DW, 32, data/register width.
REQ-002 Parameter ADDRW, 12, byte address width of the register port.
REQ-003 Parameter NO_OF_EXT_IRQS, 8, external interrupt channel count, legal range 1..31.
REQ-004 Parameter PRESCALE, 1, core clocks per mtime tick, >= 1.
REQ-005 clk_i  input  1  single clock, all logic on rising edge.
REQ-006 rst_i  input  1  reset, synchronous, active-high.
REQ-007 we_i  input  1  register write strobe.
REQ-008 re_i  input  1  register read strobe.
REQ-009 addr_i  input  ADDRW  word-aligned byte address; addr_i[1:0] ignored.
REQ-010 wdata_i  input  DW  write data.
REQ-011 rdata_o  output  DW  read data.
REQ-012 rvalid_o  output  1  read data valid.
REQ-013 ext_irq_i  input  NO_OF_EXT_IRQS  asynchronous external request lines.
REQ-014 t_intr  output  1  timer interrupt to core CSR logic.
REQ-015 e_intr  output  1  external interrupt to core CSR logic.

Function
REQ-016 Register map: 0x00 MTIME_LO, 0x04 MTIME_HI, 0x08 MTIMECMP_LO, 0x0C MTIMECMP_HI, 0x10 IE, 0x14 IP, 0x18 MODE, 0x1C CLAIM; other addresses read 0, writes ignored.
REQ-017 mtime is 64-bit, increments by 1 every PRESCALE cycles via a prescale counter, wraps 2^64-1 -> 0.
REQ-018 A write to MTIME_LO/HI replaces that half and resets the prescale counter; write wins over a same-cycle increment.
REQ-019 t_intr is registered: t_intr = (mtime >= mtimecmp) evaluated on the previous cycle's values, 1-cycle latency.
REQ-020 Each ext_irq_i bit passes a 2-flop synchronizer; edge detection is on the synchronized signal.
REQ-021 MODE bit n = 1: edge mode, rising edge sets IP[n]; MODE bit n = 0: level mode, IP[n] follows synchronized level.
REQ-022 Writing IP with bit n = 1 clears an edge-mode IP[n]; writes to level-mode IP bits are ignored.
REQ-023 Same-cycle set and clear (write or claim) of IP[n]: set wins.
REQ-024 e_intr is registered: e_intr = |(IP & IE) of the previous cycle.
REQ-025 CLAIM read returns (lowest index n with IP[n]&IE[n]) + 1, or 0 if none; it clears IP[n] if channel n is edge mode, with no other side effect.
REQ-026 Reads: rdata_o/rvalid_o valid exactly 1 cycle after re_i; rvalid_o = 0 and rdata_o holds its last value otherwise.
REQ-027 IE, IP, MODE bits above NO_OF_EXT_IRQS-1 read 0 and are not writable.
REQ-028 Simultaneous we_i and re_i: write and read both take effect; the read returns pre-write contents.
REQ-029 A MODE change on channel n clears IP[n] in the same cycle.

Reset
REQ-030 On rst_i at a clock edge: mtime = 0, prescale counter = 0, mtimecmp = all ones, IE = IP = MODE = 0, synchronizers = 0.
REQ-031 On reset: t_intr = 0, e_intr = 0, rvalid_o = 0, rdata_o = 0; reset mid-read drops the pending read response.
REQ-032 First synchronized ext edge is possible no earlier than 3 cycles after rst_i deasserts.

Structure
REQ-033 Package irq_ctrl_pkg holds register offset constants and the edge/level mode enum.
REQ-034 Sub-module irq_sync_edge: one channel, 2-flop synchronizer plus rising-edge pulse, instantiated NO_OF_EXT_IRQS times.

Verification
REQ-035 PRESCALE=4, MTIMECMP=10, MTIME=0 -> t_intr rises on the cycle after mtime reaches 10 (about 41 cycles), stays high until MTIMECMP rewritten to 0xFFFF_FFFF.
REQ-036 MODE=0x01, IE=0x01, single 1-cycle ext_irq_i[0] pulse -> IP=0x01, e_intr high 4 cycles later; CLAIM read returns 1, IP=0, e_intr low next cycle.
REQ-037 IE=0xFF, edges on channels 5 and 2 -> CLAIM returns 3 then 6 then 0.
REQ-038 Level channel 3 held high, IE=0x08 -> IP write 0x08 ignored, e_intr stays 1; drop line -> e_intr 0 after 3 cycles.
REQ-039 Edge on channel 1 in same cycle as IP write 0x02 -> IP[1] stays 1.
REQ-040 MTIME_HI=0, MTIME_LO=0xFFFF_FFFF, PRESCALE=1 -> next cycle reads MTIME_HI=1, MTIME_LO=0; rst_i mid-count -> all REQ-030/031 values.
